// File: rtl/intersection_phase_ctrl_if.sv
// Intersection controller request/lamp bundle.
// Master drives the sensors; slave is the controller.
interface intersection_phase_ctrl_if;
  logic       veh_b_req;
  logic       ped_req;
  logic       a_red;
  logic       a_yellow;
  logic       a_green;
  logic       b_red;
  logic       b_yellow;
  logic       b_green;
  logic       walk;
  logic       ped_wait;
  logic [2:0] phase;

  modport master (
    output veh_b_req, ped_req,
    input  a_red, a_yellow, a_green,
    input  b_red, b_yellow, b_green,
    input  walk, ped_wait, phase
  );

  modport slave (
    input  veh_b_req, ped_req,
    output a_red, a_yellow, a_green,
    output b_red, b_yellow, b_green,
    output walk, ped_wait, phase
  );
endinterface

// File: rtl/intersection_phase_ctrl.sv
// Two-approach intersection phase controller with
// latched side-street and pedestrian requests.
module intersection_phase_ctrl #(
  parameter int A_MIN_GREEN  = 40,
  parameter int B_GREEN_TIME = 30,
  parameter int YELLOW_TIME  = 20,
  parameter int ALLRED_TIME  = 4,
  parameter int WALK_TIME    = 50
) (
  input logic clk,
  input logic rst,
  intersection_phase_ctrl_if.slave io
);

  localparam logic [2:0] A_GRN = 3'd0;
  localparam logic [2:0] A_YEL = 3'd1;
  localparam logic [2:0] AR1   = 3'd2;
  localparam logic [2:0] WALK  = 3'd3;
  localparam logic [2:0] B_GRN = 3'd4;
  localparam logic [2:0] B_YEL = 3'd5;
  localparam logic [2:0] AR2   = 3'd6;

  localparam logic [7:0] AMG_LAST = 8'(A_MIN_GREEN - 1);
  localparam logic [7:0] BG_LAST  = 8'(B_GREEN_TIME - 1);
  localparam logic [7:0] YEL_LAST = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] AR_LAST  = 8'(ALLRED_TIME - 1);
  localparam logic [7:0] WLK_LAST = 8'(WALK_TIME - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       b_pend_q, b_pend_d;
  logic       ped_pend_q, ped_pend_d;
  logic       b_serving;
  logic       enter_b;
  logic       enter_walk;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      A_GRN:
        if (cnt_q >= AMG_LAST && (b_pend_q || ped_pend_q))
          state_d = A_YEL;
      A_YEL:
        if (cnt_q == YEL_LAST) state_d = AR1;
      AR1:
        if (cnt_q == AR_LAST)
          state_d = ped_pend_q ? WALK : B_GRN;
      WALK:
        if (cnt_q == WLK_LAST)
          state_d = b_pend_q ? B_GRN : A_GRN;
      B_GRN:
        if (cnt_q == BG_LAST) state_d = B_YEL;
      B_YEL:
        if (cnt_q == YEL_LAST) state_d = AR2;
      AR2:
        if (cnt_q == AR_LAST) state_d = A_GRN;
      default:
        state_d = AR2;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = 8'd0;
    else if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
  end

  assign b_serving  = (state_q == B_GRN) || (state_q == B_YEL);
  assign enter_b    = (state_d == B_GRN) && (state_q != B_GRN);
  assign enter_walk = (state_d == WALK) && (state_q != WALK);

  // Clear wins: a request on the entering edge is served now.
  always_comb begin
    b_pend_d = b_pend_q;
    if (enter_b)
      b_pend_d = 1'b0;
    else if (io.veh_b_req && !b_serving)
      b_pend_d = 1'b1;
  end

  always_comb begin
    ped_pend_d = ped_pend_q;
    if (enter_walk)
      ped_pend_d = 1'b0;
    else if (io.ped_req && state_q != WALK)
      ped_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= AR2;
      cnt_q      <= 8'd0;
      b_pend_q   <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      b_pend_q   <= b_pend_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  assign io.a_green  = (state_q == A_GRN);
  assign io.a_yellow = (state_q == A_YEL);
  assign io.a_red    = !io.a_green && !io.a_yellow;
  assign io.b_green  = (state_q == B_GRN);
  assign io.b_yellow = (state_q == B_YEL);
  assign io.b_red    = !io.b_green && !io.b_yellow;
  assign io.walk     = (state_q == WALK);
  assign io.ped_wait = ped_pend_q;
  assign io.phase    = state_q;

endmodule
